tube_ctrl: RTL and testbench

Display controller that sits between the CPU's memory-mapped tube register and the seven-segment scan driver. It accepts 32-bit display writes through a single-cycle request/busy handshake. It formats each value as eight hex digits, or as eight decimal digits using a sequential 32-step double-dabble converter. It commits a stable digit word plus per-digit blanking mask to the scan driver, so the driver never sees a half-converted value.

---
 rtl/tube_ctrl_if.sv | 28 ++
 rtl/tube_ctrl.sv | 147 ++++++++++++++
 tb/tb_tube_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tube_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : tube_ctrl_if
// Description : Write handshake and committed display bus between the CPU
//               tube register and the seven-segment scan driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface tube_ctrl_if;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_mode;
    logic        busy;
    logic [31:0] disp_data;
    logic [7:0]  disp_blank;
    logic        disp_valid;
    logic        ovf;

    modport master (
        output wr_en, wr_data, wr_mode,
        input  busy, disp_data, disp_blank, disp_valid, ovf
    );

    modport slave (
        input  wr_en, wr_data, wr_mode,
        output busy, disp_data, disp_blank, disp_valid, ovf
    );
endinterface
`default_nettype wire

// File: rtl/tube_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tube_ctrl
// Description : Formats 32-bit tube writes as hex or decimal (double-dabble)
//               digits and commits a stable digit word plus blanking mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tube_ctrl #(
    parameter bit LZ_BLANK = 1'b1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    tube_ctrl_if.slave  bus
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_HEX    = 2'd1;
    localparam logic [1:0]  S_CONV   = 2'd2;
    localparam logic [1:0]  S_COMMIT = 2'd3;

    localparam logic [31:0] c_ovf_word  = 32'hEEEE_EEEE;
    localparam logic [7:0]  c_blank_rst = LZ_BLANK ? 8'hFE : 8'h00;
    localparam logic [5:0]  c_last_step = 6'd31;

    logic [1:0]  r_state;
    logic [31:0] r_bin;
    logic [39:0] r_bcd;
    logic [5:0]  r_step;
    logic        r_busy;
    logic        r_valid;
    logic        r_ovf;
    logic [31:0] r_disp_data;
    logic [7:0]  r_disp_blank;

    logic [1:0]  w_state_nxt;
    logic        w_load;
    logic        w_step;
    logic        w_commit;
    logic [31:0] w_commit_data;
    logic        w_commit_ovf;
    logic [7:0]  w_commit_blank;
    logic [7:0]  w_lz;
    logic [39:0] w_bcd_adj;
    logic [71:0] w_dd;

    // Add-3 correction on every BCD digit before the shift.
    for (genvar i = 0; i < 10; i++) begin : g_adj
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ?
                                     (r_bcd[4*i +: 4] + 4'd3) : r_bcd[4*i +: 4];
    end

    assign w_dd = {w_bcd_adj, r_bin} << 1;

    // Digit i blanks only when it and every digit to its left are zero.
    assign w_lz[7] = (w_commit_data[31:28] == 4'd0);
    for (genvar i = 1; i < 7; i++) begin : g_lz
        assign w_lz[i] = w_lz[i+1] && (w_commit_data[4*i +: 4] == 4'd0);
    end
    assign w_lz[0] = 1'b0;

    assign w_commit_blank = (LZ_BLANK && !w_commit_ovf) ? w_lz : 8'h00;

    always_comb begin
        w_state_nxt   = r_state;
        w_load        = 1'b0;
        w_step        = 1'b0;
        w_commit      = 1'b0;
        w_commit_data = r_bin;
        w_commit_ovf  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.wr_en && !r_busy) begin
                    w_load      = 1'b1;
                    w_state_nxt = bus.wr_mode ? S_CONV : S_HEX;
                end
            end
            S_HEX: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_CONV: begin
                w_step = 1'b1;
                if (r_step == c_last_step) begin
                    w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_IDLE;
                if (|r_bcd[39:32]) begin
                    w_commit_ovf  = 1'b1;
                    w_commit_data = c_ovf_word;
                end else begin
                    w_commit_data = r_bcd[31:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bin        <= 32'd0;
            r_bcd        <= 40'd0;
            r_step       <= 6'd0;
            r_busy       <= 1'b0;
            r_valid      <= 1'b0;
            r_ovf        <= 1'b0;
            r_disp_data  <= 32'd0;
            r_disp_blank <= c_blank_rst;
        end else begin
            r_valid <= w_commit;
            if (w_load) begin
                r_bin  <= bus.wr_data;
                r_bcd  <= 40'd0;
                r_step <= 6'd0;
                r_busy <= 1'b1;
            end else if (w_step) begin
                r_bcd  <= w_dd[71:32];
                r_bin  <= w_dd[31:0];
                r_step <= r_step + 6'd1;
            end
            if (w_commit) begin
                r_busy       <= 1'b0;
                r_ovf        <= w_commit_ovf;
                r_disp_data  <= w_commit_data;
                r_disp_blank <= w_commit_blank;
            end
        end
    end

    assign bus.busy       = r_busy;
    assign bus.disp_valid = r_valid;
    assign bus.ovf        = r_ovf;
    assign bus.disp_data  = r_disp_data;
    assign bus.disp_blank = r_disp_blank;

endmodule
`default_nettype wire

// File: tb/tb_tube_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tube_ctrl
// Description : Scoreboard bench for tube_ctrl with directed write vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tube_ctrl;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  blank;
        logic        ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   valid_count;
    int   exp_valids;
    logic prev_valid;
    exp_t exp_q[$];

    tube_ctrl_if bus_if ();

    tube_ctrl #(.LZ_BLANK(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [7:0] b, input logic o);
        exp_t e;
        e.data  = d;
        e.blank = b;
        e.ovf   = o;
        exp_q.push_back(e);
        exp_valids++;
    endtask

    // Drive one write request for a single cycle.
    task automatic issue(input logic [31:0] d, input logic m);
        @(negedge clk);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = d;
        bus_if.wr_mode = m;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cycles);
        int cnt;
        cnt = 0;
        while (bus_if.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: busy still high after %0d cycles", name, cnt);
        end
        if (exp_cycles > 0) check({name, "_busy_cycles"}, cnt, exp_cycles);
        repeat (2) @(negedge clk);
        check({name, "_valid_count"}, valid_count, exp_valids);
    endtask

    // Monitor: compares every committed result against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus_if.disp_valid) begin
            exp_t e;
            valid_count++;
            if (prev_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL valid_width: disp_valid high for more than one cycle");
            end
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: data %h with empty scoreboard", bus_if.disp_data);
            end else begin
                e = exp_q.pop_front();
                check("disp_data",  bus_if.disp_data,         e.data);
                check("disp_blank", {24'd0, bus_if.disp_blank}, {24'd0, e.blank});
                check("ovf",        {31'd0, bus_if.ovf},        {31'd0, e.ovf});
            end
        end
        prev_valid = bus_if.disp_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        valid_count    = 0;
        exp_valids     = 0;
        prev_valid     = 1'b0;
        rst_n          = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 32'd0;
        bus_if.wr_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_busy",  {31'd0, bus_if.busy},       32'd0);
        check("rst_valid", {31'd0, bus_if.disp_valid}, 32'd0);
        check("rst_ovf",   {31'd0, bus_if.ovf},        32'd0);
        check("rst_data",  bus_if.disp_data,           32'd0);
        check("rst_blank", {24'd0, bus_if.disp_blank}, 32'h0000_00FE);

        push(32'h5678_9ABC, 8'h00, 1'b0);
        issue(32'h5678_9ABC, 1'b0);
        wait_done("hex_5678", 1);

        push(32'h1234_5678, 8'h00, 1'b0);
        issue(32'h00BC_614E, 1'b1);
        wait_done("dec_12345678", 33);

        push(32'h0000_0042, 8'hFC, 1'b0);
        issue(32'd42, 1'b1);
        wait_done("dec_42", 33);

        push(32'h0000_0000, 8'hFE, 1'b0);
        issue(32'd0, 1'b0);
        wait_done("hex_0", 1);

        push(32'hEEEE_EEEE, 8'h00, 1'b1);
        issue(32'd100_000_000, 1'b1);
        wait_done("dec_ovf", 33);

        push(32'h0000_0001, 8'hFE, 1'b0);
        issue(32'h0000_0001, 1'b0);
        wait_done("hex_1", 1);

        // Write during conversion must be dropped.
        push(32'h0000_0042, 8'hFC, 1'b0);
        issue(32'd42, 1'b1);
        repeat (4) @(negedge clk);
        issue(32'hFFFF_FFFF, 1'b0);
        wait_done("dec_42_ignore", 0);

        // Reset in the middle of a conversion aborts it silently.
        issue(32'h00BC_614E, 1'b1);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy",  {31'd0, bus_if.busy},       32'd0);
        check("abort_valid", {31'd0, bus_if.disp_valid}, 32'd0);
        check("abort_ovf",   {31'd0, bus_if.ovf},        32'd0);
        check("abort_data",  bus_if.disp_data,           32'd0);
        check("abort_blank", {24'd0, bus_if.disp_blank}, 32'h0000_00FE);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_valid_count", valid_count, exp_valids);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
